// File: rtl/uart_rx_periph_pkg.sv
// Shared definitions for the UART receive peripheral: register map, STATUS bit
// positions, receiver state encoding and the baud divider calculation.
package uart_rx_periph_pkg;

  localparam logic [3:0] UART_RX_ADDR_DATA   = 4'h0;
  localparam logic [3:0] UART_RX_ADDR_STATUS = 4'h2;

  localparam int STAT_VALID_BIT = 0;
  localparam int STAT_OVR_BIT   = 1;
  localparam int STAT_FERR_BIT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Clocks per 16x oversampling tick, truncated, never below one.
  function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
    int unsigned d;
    d = clk_freq / (baud * 32'd16);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_periph_if.sv
// Register-bus bundle between the J1 I/O decoder (master) and the UART receiver (slave).
interface uart_rx_periph_if;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [3:0]  addr;
  logic [15:0] d_in;
  logic [15:0] d_out;

  modport master (output cs, rd, wr, addr, d_in, input d_out);
  modport slave  (input cs, rd, wr, addr, d_in, output d_out);
endinterface

// File: rtl/uart_rx_periph_fifo.sv
// Circular byte buffer for the UART receiver: wrapping pointers plus an occupancy count.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    data_i,
  output logic [7:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full_o    = (r_count == (AW+1)'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;
  assign data_o    = r_mem[r_rd_ptr];
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  // Storage array, written at the tail
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_periph.sv
// 8N1 UART receiver with 16x oversampling and a register-mapped receive buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise one holding byte.
module uart_rx_periph
  import uart_rx_periph_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  uart_rx_periph_if.slave   bus,
  input  logic              uart_rx,
  output logic              rx_irq
);
  localparam int unsigned DIV      = baud_div(CLK_FREQ, BAUD);
  localparam logic [15:0] DIV_LAST = 16'(DIV - 32'd1);

  logic [15:0] r_div_cnt;
  logic        r_sync1, r_sync2, r_rx_prev;
  rx_state_e   r_state, w_state_nxt;
  logic [3:0]  r_tick_cnt, w_tick_nxt;
  logic [2:0]  r_bit_cnt, w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_ovr, r_ferr, r_irq;
  logic [15:0] r_d_out;
  logic        w_tick, w_fall, w_push, w_ferr_set;
  logic        w_rd, w_pop, w_wr_stat, w_push_ok, w_ovr_set;
  logic        w_valid, w_full, w_multi, w_valid_nxt;
  logic [7:0]  w_head;
  logic        w_unused;

  assign w_tick    = (r_div_cnt == DIV_LAST);
  assign w_fall    = r_rx_prev & ~r_sync2;
  assign w_rd      = bus.cs & bus.rd;
  assign w_pop     = w_rd & (bus.addr == UART_RX_ADDR_DATA) & w_valid;
  assign w_wr_stat = bus.cs & bus.wr & (bus.addr == UART_RX_ADDR_STATUS);
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovr_set = w_push & w_full & ~w_pop;
  assign w_valid_nxt = w_push_ok | (w_valid & ~w_pop) | w_multi;
  assign bus.d_out = r_d_out;
  assign rx_irq    = r_irq;
  assign w_unused  = ^{bus.d_in[15:3], bus.d_in[0]};

  // Free-running oversampling divider
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) r_div_cnt <= 16'd0;
    else            r_div_cnt <= w_tick ? 16'd0 : r_div_cnt + 16'd1;
  end

  // Line synchronizer and previous-sample flop for edge detection
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= uart_rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  // Receiver state and datapath registers
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= 4'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  // Frame sequencing: start checked at 8 ticks, data and stop at 16-tick intervals
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_nxt = ST_START;
          w_tick_nxt  = 4'd0;
        end
      end
      ST_START: begin
        if (w_tick && r_tick_cnt == 4'd7) begin
          w_tick_nxt  = 4'd0;
          w_bit_nxt   = 3'd0;
          w_state_nxt = r_sync2 ? ST_IDLE : ST_DATA;
        end else if (w_tick) begin
          w_tick_nxt = r_tick_cnt + 4'd1;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_tick_nxt = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd15) begin
            w_shift_nxt = {r_sync2, r_shift[7:1]};
            w_bit_nxt   = r_bit_cnt + 3'd1;
            w_state_nxt = (r_bit_cnt == 3'd7) ? ST_STOP : ST_DATA;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_tick_nxt = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd15) begin
            w_push      = r_sync2;
            w_ferr_set  = ~r_sync2;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [CW-1:0] w_count;
  logic          w_empty;

  uart_rx_fifo #(.DEPTH(int'(FIFO_DEPTH))) u_fifo (
    .clk_i   (sys_clk_i),
    .rst_ni  (sys_rst_i),
    .push_i  (w_push_ok),
    .pop_i   (w_pop),
    .data_i  (r_shift),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );
  assign w_valid = ~w_empty;
  assign w_multi = |w_count[CW-1:1];
`else
  logic [7:0] r_hold;
  logic       r_hold_vld;

  // Single holding register; a pop in the same cycle frees it for the push
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_hold     <= 8'd0;
      r_hold_vld <= 1'b0;
    end else if (w_push_ok) begin
      r_hold     <= r_shift;
      r_hold_vld <= 1'b1;
    end else if (w_pop) begin
      r_hold_vld <= 1'b0;
    end
  end
  assign w_head  = r_hold;
  assign w_valid = r_hold_vld;
  assign w_full  = r_hold_vld;
  assign w_multi = 1'b0;
`endif

  // Sticky error flags (set wins), interrupt, and registered read data
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
      r_irq   <= 1'b0;
      r_d_out <= 16'h0000;
    end else begin
      if (w_ovr_set)                              r_ovr <= 1'b1;
      else if (w_wr_stat && bus.d_in[STAT_OVR_BIT]) r_ovr <= 1'b0;
      if (w_ferr_set)                              r_ferr <= 1'b1;
      else if (w_wr_stat && bus.d_in[STAT_FERR_BIT]) r_ferr <= 1'b0;
      r_irq <= w_valid_nxt;
      if (w_rd) begin
        case (bus.addr)
          UART_RX_ADDR_DATA:   r_d_out <= w_valid ? {8'h00, w_head} : 16'h0000;
          UART_RX_ADDR_STATUS: r_d_out <= {13'h0000, r_ferr, r_ovr, w_valid};
          default:             r_d_out <= 16'h0000;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_periph.sv
// Randomized self-checking bench for uart_rx_periph against a queue-based model.
module tb_uart_rx_periph;
  import uart_rx_periph_pkg::*;

  localparam int unsigned CLK_FREQ = 50000000;
  localparam int unsigned BAUD     = 115200;
  localparam int BIT_CLKS = int'((CLK_FREQ / (BAUD * 16)) * 16);
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic line  = 1'b1;
  logic irq;
  uart_rx_periph_if bus ();

  uart_rx_periph #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(8)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst_n),
    .bus       (bus),
    .uart_rx   (line),
    .rx_irq    (irq)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [7:0] mq[$];
  bit m_ovr  = 1'b0;
  bit m_ferr = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
    @(negedge clk);
    bus.cs = 1'b0; bus.rd = 1'b0;
    d = bus.d_out;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [15:0] v);
    @(negedge clk);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.d_in = v;
    @(negedge clk);
    bus.cs = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  // Serialize one 8N1 frame and fold its outcome into the model
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    line = 1'b0;
    clocks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      clocks(BIT_CLKS);
    end
    line = stop_ok;
    clocks(BIT_CLKS / 4);
    check("irq_before_stop", {15'd0, irq}, {15'd0, mq.size() != 0});
    clocks(BIT_CLKS - BIT_CLKS / 4);
    line = 1'b1;
    clocks(BIT_CLKS / 2);
    if (!stop_ok)                 m_ferr = 1'b1;
    else if (mq.size() < DEPTH)   mq.push_back(b);
    else                          m_ovr = 1'b1;
    check("irq_after_frame", {15'd0, irq}, {15'd0, mq.size() != 0});
  endtask

  task automatic chk_data(input string tag);
    logic [15:0] d, e;
    e = (mq.size() != 0) ? {8'h00, mq.pop_front()} : 16'h0000;
    bus_rd(UART_RX_ADDR_DATA, d);
    check(tag, d, e);
  endtask

  task automatic chk_status(input string tag);
    logic [15:0] d;
    bus_rd(UART_RX_ADDR_STATUS, d);
    check(tag, d, {13'd0, m_ferr, m_ovr, mq.size() != 0});
  endtask

  task automatic wr_status(input logic [15:0] v);
    bus_wr(UART_RX_ADDR_STATUS, v);
    if (v[1]) m_ovr  = 1'b0;
    if (v[2]) m_ferr = 1'b0;
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0]  rb;
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 4'h0; bus.d_in = 16'h0000;
    #2 rst_n = 1'b0;
    clocks(5);
    check("rst_dout", bus.d_out, 16'h0000);
    check("rst_irq", {15'd0, irq}, 16'h0000);
    rst_n = 1'b1;
    clocks(20);
    chk_status("rst_status");
    chk_data("empty_data");

    // Basic byte, plus reserved-address and DATA-write decoding
    send_frame(8'hA5, 1'b1);
    bus_rd(4'h1, d);
    check("reserved_rd", d, 16'h0000);
    bus_wr(UART_RX_ADDR_DATA, 16'hFFFF);
    chk_status("status_held");
    chk_data("a5_data");
    clocks(3);
    check("dout_hold", bus.d_out, 16'h00A5);
    check("irq_after_pop", {15'd0, irq}, {15'd0, mq.size() != 0});
    chk_status("a5_status");

    // Short low glitch must not start a frame
    line = 1'b0;
    clocks(2);
    line = 1'b1;
    clocks(400);
    check("glitch_irq", {15'd0, irq}, 16'h0000);
    chk_status("glitch_status");

    // Framing error then clear
    send_frame(8'h3C, 1'b0);
    chk_status("ferr_status");
    wr_status(16'h0004);
    chk_status("ferr_cleared");

    // Overrun
`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    chk_status("fifo_full_status");
    for (int i = 0; i < 9; i++) chk_data("fifo_drain");
`else
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    chk_data("ovr_data");
    chk_status("ovr_status");
`endif
    wr_status(16'h0002);
    chk_status("ovr_cleared");

    // Reset in the middle of a frame while a byte is buffered
    send_frame(8'h77, 1'b1);
    chk_status("pre_reset_status");
    line = 1'b0;
    clocks(BIT_CLKS);
    for (int i = 0; i < 4; i++) clocks(BIT_CLKS);
    line = 1'b1;
    clocks(BIT_CLKS / 2);
    rst_n = 1'b0;
    clocks(5);
    check("midrst_dout", bus.d_out, 16'h0000);
    check("midrst_irq", {15'd0, irq}, 16'h0000);
    rst_n = 1'b1;
    model_reset();
    clocks(BIT_CLKS * 4);
    chk_status("post_reset_status");
    send_frame(8'h5A, 1'b1);
    chk_data("post_reset_5a");

    // Random frames with random register traffic
    for (int n = 0; n < 5; n++) begin
      rb = 8'($urandom);
      send_frame(rb, $urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       chk_data("rand_data");
        1:       chk_status("rand_status");
        2:       wr_status(16'($urandom));
        default: clocks(1);
      endcase
    end
    chk_status("final_status");
    while (mq.size() != 0) chk_data("final_drain");
    chk_data("final_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
